alu_flag_stage: RTL and testbench
=================================

# alu_flag_stage

Registered flag/result stage sitting directly downstream of the carry-out OR stage (`orgate_cout`) in the 8-bit structural ALU. It captures each 8-bit result together with the final carry `f`, and derives Z, N and V. It holds an architectural flag register whose carry feeds back to the adder as carry-in for multi-byte (chained) operations. Results leave through a 2-entry valid/ready buffer so downstream stalls never drop an operation.

## Interface
Parameters:
- `WIDTH`, default 8: result width; MSB index is `WIDTH-1`.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `in_valid`, input, 1: upstream result/carry valid.
- `in_ready`, output, 1: stage can accept; equals "buffer not full".
- `res`, input, WIDTH: adder sum bits.
- `cout`, input, 1: carry-out from the OR carry stage.
- `a_msb`, input, 1: MSB of operand A.
- `b_msb`, input, 1: MSB of operand B.
- `op_sub`, input, 1: operation is a subtract; B is inverted internally for V.
- `chain`, input, 1: this byte continues a multi-byte op; Z accumulates.
- `clr_flags`, input, 1: synchronous clear of the flag register.
- `cin_q`, output, 1: registered carry flag, fed back as adder carry-in.
- `out_valid`, output, 1: output entry valid.
- `out_ready`, input, 1: downstream accepts.
- `out_res`, output, WIDTH: buffered result.
- `out_c`, `out_z`, `out_n`, `out_v`, output, 1 each: buffered flags for that result.

## Operation
- Accept occurs when `in_valid && in_ready`. Pop occurs when `out_valid && out_ready`.
- Flag computation at accept:
  - C = `cout`.
  - N = `res[WIDTH-1]`.
  - zb = (`res` == 0).
  - Z = zb && (chain ? z_q : 1).
  - V = (`a_msb` XNOR (`b_msb` XOR `op_sub`)) AND (`res[WIDTH-1]` XOR `a_msb`).
- Flag register {c_q, z_q, n_q, v_q} loads the computed flags on every accept. `cin_q` = c_q.
- `clr_flags` without accept: flag register goes to 0.
- `clr_flags` with accept in the same cycle: the accept loads. It is evaluated with `chain` forced to 0, so Z = zb.
- Buffer is a 2-entry FIFO of {res, C, Z, N, V}, states EMPTY, ONE, FULL:
  - EMPTY, accept: go to ONE.
  - ONE, accept only: go to FULL.
  - ONE, pop only: go to EMPTY.
  - ONE, accept and pop in the same cycle: stay ONE; the new entry becomes head.
  - FULL, pop: go to ONE. No accept is possible in FULL because `in_ready`=0.
- Outputs come from the head entry. While `out_valid && !out_ready`, `out_res` and all `out_*` flags hold stable.
- `in_ready` = (state != FULL). It does not depend on `out_ready`, so there is no combinational path in→out.
- Inputs other than `in_valid`/`out_ready` are don't-care when no accept occurs.

## Timing
- Reset (`rst_n`=0, asynchronous):
  - state=EMPTY, all flags 0, `cin_q`=0, `out_valid`=0.
  - `out_res`=0 and `out_c`/`out_z`/`out_n`/`out_v`=0.
  - `in_ready`=1.
  - Inputs presented while `rst_n`=0 are ignored.
- Deassertion is sampled at the next rising edge; the first accept can occur on that edge.
- Latency: accept at edge k gives `out_valid`=1 after edge k (visible in cycle k+1) when the buffer was EMPTY. `cin_q` updates after the same edge.
- Throughput: 1 op/cycle while `out_ready`=1. Two consecutive stalled cycles fill the buffer, and `in_ready` drops after the second accept.
- Reset mid-operation: buffered entries are discarded and flags cleared immediately. No pop is reported.

## Test plan
- Reset/idle: assert `rst_n`=0 with `in_valid`=1 → `out_valid`=0, `cin_q`=0, `in_ready`=1. Release reset → no spurious output.
- Add overflow: `res`=0x80, `cout`=0, `a_msb`=0, `b_msb`=0, `op_sub`=0, `out_ready`=1 → one cycle later `out_res`=0x80, C=0, Z=0, N=1, V=1.
- Chained zero: byte0 `res`=0x00, `cout`=1, `chain`=0, then byte1 `res`=0x00, `chain`=1 → byte1 Z=1 and `cin_q`=1 after byte0. Repeat with byte0 `res`=0x01 → byte1 Z=0.
- Backpressure: `out_ready`=0 and three back-to-back valid results 0x11, 0x22, 0x33:
  - 0x11 and 0x22 are accepted; `in_ready`=0 holds 0x33.
  - `out_res` stays 0x11.
  - Raise `out_ready` → outputs appear in order 0x11, 0x22, 0x33 with none lost.
- Simultaneous push/pop in ONE: steady stream with `out_ready`=1 → state stays ONE and output matches input delayed by exactly 1 cycle.
- Clear collision:
  - `clr_flags`=1 with an accept of `res`=0x00, `chain`=1, `cout`=1, while z_q was 0 → Z=1 (chain ignored), `cin_q`=1.
  - `clr_flags` alone → `cin_q`=0.

Source files
------------

// File: rtl/alu_flag_stage_if.sv
// alu_flag_stage_if
// Bundles the handshake and data signals of the ALU flag/result stage.
//   upstream : in_valid, in_ready, res, cout, a_msb, b_msb, op_sub, chain,
//              clr_flags
//   feedback : cin_q (registered carry returned to the adder carry-in)
//   downstream: out_valid, out_ready, out_res, out_c, out_z, out_n, out_v
// The slave modport is the stage itself. The master modport is the
// environment around it, which drives upstream data and the downstream ready.
interface alu_flag_stage_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] res;
  logic             cout;
  logic             a_msb;
  logic             b_msb;
  logic             op_sub;
  logic             chain;
  logic             clr_flags;
  logic             cin_q;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_res;
  logic             out_c;
  logic             out_z;
  logic             out_n;
  logic             out_v;

  modport slave (
    input  in_valid, res, cout, a_msb, b_msb, op_sub, chain, clr_flags,
    input  out_ready,
    output in_ready, cin_q, out_valid, out_res, out_c, out_z, out_n, out_v
  );

  modport master (
    output in_valid, res, cout, a_msb, b_msb, op_sub, chain, clr_flags,
    output out_ready,
    input  in_ready, cin_q, out_valid, out_res, out_c, out_z, out_n, out_v
  );
endinterface

// File: rtl/alu_flag_stage.sv
// alu_flag_stage
// Registered flag/result stage placed after the carry-out OR stage of the
// 8-bit structural ALU. Each accepted result is stored with its C/Z/N/V flags
// in a 2-entry valid/ready buffer. An architectural flag register keeps the
// last flags, and its carry is returned to the adder as carry-in for chained
// multi-byte operations.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   s     : alu_flag_stage_if.slave (upstream data, feedback carry, output)
//
// state | meaning
// ------+------------------------------------------------
// EMPTY | no buffered entry, out_valid=0, in_ready=1
// ONE   | head holds one entry, out_valid=1, in_ready=1
// FULL  | head and tail both hold entries, in_ready=0
module alu_flag_stage #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_flag_stage_if.slave      s
);

  localparam int EW = WIDTH + 4;  // entry = {res, c, z, n, v}

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t          state_q;
  logic [EW-1:0]   head_q;
  logic [EW-1:0]   tail_q;
  logic            out_valid_q;
  logic            in_ready_q;
  logic            c_q;
  logic            z_q;
  logic            n_q;
  logic            v_q;

  logic            accept;
  logic            pop;
  logic            zb;
  logic            z_d;
  logic            n_d;
  logic            v_d;
  logic [EW-1:0]   entry_d;

  always_comb begin
    accept  = s.in_valid && in_ready_q;
    pop     = out_valid_q && s.out_ready;
    zb      = (s.res == '0);
    // A clear in the same cycle breaks the chain, so Z comes from this byte only.
    z_d     = zb && ((s.chain && !s.clr_flags) ? z_q : 1'b1);
    n_d     = s.res[WIDTH-1];
    // Signed overflow: operands (B inverted on subtract) share a sign that
    // differs from the result sign.
    v_d     = (~(s.a_msb ^ (s.b_msb ^ s.op_sub))) & (s.res[WIDTH-1] ^ s.a_msb);
    entry_d = {s.res, s.cout, z_d, n_d, v_d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      head_q      <= '0;
      tail_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      c_q         <= 1'b0;
      z_q         <= 1'b0;
      n_q         <= 1'b0;
      v_q         <= 1'b0;
    end else begin
      if (accept) begin
        c_q <= s.cout;
        z_q <= z_d;
        n_q <= n_d;
        v_q <= v_d;
      end else if (s.clr_flags) begin
        c_q <= 1'b0;
        z_q <= 1'b0;
        n_q <= 1'b0;
        v_q <= 1'b0;
      end

      case (state_q)
        EMPTY: begin
          if (accept) begin
            head_q      <= entry_d;
            state_q     <= ONE;
            out_valid_q <= 1'b1;
          end
        end
        ONE: begin
          if (accept && pop) begin
            // Old head leaves this edge, so the new entry replaces it directly.
            head_q <= entry_d;
          end else if (accept) begin
            tail_q     <= entry_d;
            state_q    <= FULL;
            in_ready_q <= 1'b0;
          end else if (pop) begin
            state_q     <= EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        FULL: begin
          if (pop) begin
            head_q     <= tail_q;
            state_q    <= ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= EMPTY;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign s.in_ready  = in_ready_q;
  assign s.cin_q     = c_q;
  assign s.out_valid = out_valid_q;
  assign s.out_res   = head_q[EW-1:4];
  assign s.out_c     = head_q[3];
  assign s.out_z     = head_q[2];
  assign s.out_n     = head_q[1];
  assign s.out_v     = head_q[0];

endmodule

// File: tb/tb_alu_flag_stage.sv
module tb_alu_flag_stage;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  alu_flag_stage_if #(.WIDTH(8)) bus ();

  alu_flag_stage #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] res;
    logic       cout;
    logic       a_msb;
    logic       b_msb;
    logic       op_sub;
    logic       chain;
    logic       clr;
    logic       ec;
    logic       ez;
    logic       en;
    logic       ev;
    logic       ecin;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] r, input logic co, input logic a, input logic b,
                       input logic sub, input logic ch, input logic clr);
    bus.res       = r;
    bus.cout      = co;
    bus.a_msb     = a;
    bus.b_msb     = b;
    bus.op_sub    = sub;
    bus.chain     = ch;
    bus.clr_flags = clr;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    //            res    co a  b  sub ch clr  C  Z  N  V  cin
    vecs[0] = '{8'h80, 0, 0, 0, 0,  0, 0,  0, 0, 1, 1, 0};
    vecs[1] = '{8'h00, 1, 1, 1, 0,  0, 0,  1, 1, 0, 1, 1};
    vecs[2] = '{8'h00, 0, 0, 0, 0,  1, 0,  0, 1, 0, 0, 0};
    vecs[3] = '{8'h01, 1, 0, 1, 1,  0, 0,  1, 0, 0, 0, 1};
    vecs[4] = '{8'h00, 0, 1, 0, 1,  1, 0,  0, 0, 0, 1, 0};
    vecs[5] = '{8'h00, 1, 0, 0, 0,  1, 1,  1, 1, 0, 0, 1};
    vecs[6] = '{8'h7F, 0, 0, 1, 1,  0, 0,  0, 0, 0, 0, 0};
    vecs[7] = '{8'hFF, 1, 1, 1, 0,  0, 0,  1, 0, 1, 0, 1};
    vecs[8] = '{8'h40, 1, 1, 1, 0,  0, 0,  1, 0, 0, 1, 1};

    // Reset with valid data present: must be ignored.
    rst_n         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    drive(8'hA5, 1, 1, 0, 0, 0, 0);
    repeat (3) cyc();
    chk("rst_out_valid", {31'd0, bus.out_valid}, 0);
    chk("rst_cin_q", {31'd0, bus.cin_q}, 0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 1);
    chk("rst_out_res", {24'd0, bus.out_res}, 0);
    chk("rst_out_flags", {28'd0, bus.out_c, bus.out_z, bus.out_n, bus.out_v}, 0);
    bus.in_valid = 1'b0;
    rst_n        = 1'b1;
    cyc();
    cyc();
    chk("post_rst_out_valid", {31'd0, bus.out_valid}, 0);

    // Streaming vectors: each result appears one cycle after it is offered.
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].res, vecs[i].cout, vecs[i].a_msb, vecs[i].b_msb,
            vecs[i].op_sub, vecs[i].chain, vecs[i].clr);
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      cyc();
      chk($sformatf("v%0d_valid", i), {31'd0, bus.out_valid}, 1);
      chk($sformatf("v%0d_res", i), {24'd0, bus.out_res}, {24'd0, vecs[i].res});
      chk($sformatf("v%0d_flags", i), {28'd0, bus.out_c, bus.out_z, bus.out_n, bus.out_v},
          {28'd0, vecs[i].ec, vecs[i].ez, vecs[i].en, vecs[i].ev});
      chk($sformatf("v%0d_cin", i), {31'd0, bus.cin_q}, {31'd0, vecs[i].ecin});
      chk($sformatf("v%0d_in_ready", i), {31'd0, bus.in_ready}, 1);
    end

    // Clear alone drops the carry; the remaining entry drains.
    bus.in_valid = 1'b0;
    drive(8'h00, 0, 0, 0, 0, 0, 1);
    cyc();
    chk("clr_cin_q", {31'd0, bus.cin_q}, 0);
    chk("drain_out_valid", {31'd0, bus.out_valid}, 0);
    bus.clr_flags = 1'b0;

    // Backpressure: 0x11 and 0x22 fill the buffer, 0x33 is held off.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    drive(8'h11, 0, 0, 0, 0, 0, 0);
    cyc();
    chk("bp1_res", {24'd0, bus.out_res}, 32'h11);
    chk("bp1_in_ready", {31'd0, bus.in_ready}, 1);
    drive(8'h22, 0, 0, 0, 0, 0, 0);
    cyc();
    chk("bp2_res", {24'd0, bus.out_res}, 32'h11);
    chk("bp2_in_ready", {31'd0, bus.in_ready}, 0);
    drive(8'h33, 0, 0, 0, 0, 0, 0);
    cyc();
    chk("bp3_res_hold", {24'd0, bus.out_res}, 32'h11);
    chk("bp3_in_ready", {31'd0, bus.in_ready}, 0);
    chk("bp3_valid", {31'd0, bus.out_valid}, 1);
    bus.out_ready = 1'b1;
    #1;
    chk("bp_pop0_res", {24'd0, bus.out_res}, 32'h11);
    cyc();
    chk("bp_pop1_res", {24'd0, bus.out_res}, 32'h22);
    chk("bp_pop1_in_ready", {31'd0, bus.in_ready}, 1);
    cyc();
    chk("bp_pop2_res", {24'd0, bus.out_res}, 32'h33);
    chk("bp_pop2_valid", {31'd0, bus.out_valid}, 1);
    bus.in_valid = 1'b0;
    cyc();
    chk("bp_empty", {31'd0, bus.out_valid}, 0);

    // Chained zero with a non-zero low byte: Z must not survive.
    drive(8'h01, 1, 0, 0, 0, 0, 0);
    bus.in_valid = 1'b1;
    cyc();
    chk("ch_b0_cin", {31'd0, bus.cin_q}, 1);
    drive(8'h00, 0, 0, 0, 0, 1, 0);
    cyc();
    chk("ch_b1_z", {31'd0, bus.out_z}, 0);

    // Asynchronous reset mid-operation discards buffered data immediately.
    bus.out_ready = 1'b0;
    drive(8'h5A, 1, 0, 0, 0, 0, 0);
    cyc();
    chk("mid_pre_valid", {31'd0, bus.out_valid}, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, bus.out_valid}, 0);
    chk("mid_rst_cin", {31'd0, bus.cin_q}, 0);
    chk("mid_rst_in_ready", {31'd0, bus.in_ready}, 1);
    bus.in_valid = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("mid_post_valid", {31'd0, bus.out_valid}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
